// File: rtl/acsp_pkg.sv
// Shared definitions for the acquisition readout path.
//   readout_state_t   : readout FSM / byte handshake state encoding
//   UART_BYTE_W       : width of one UART data byte
//   bytes_per_sample  : number of UART bytes needed to carry one sample
package acsp_pkg;

   localparam int unsigned UART_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_DATA,
      SEND,
      WAIT_ACK,
      WAIT_DONE,
      CHECKSUM,
      FINISH
   } readout_state_t;

   function automatic int unsigned bytes_per_sample(input int unsigned width);
      return (width + UART_BYTE_W - 1) / UART_BYTE_W;
   endfunction

endpackage

// File: rtl/uart_byte_handshake.sv
// Single-byte transmit handshake towards the UART.
// A request latches tx_byte; the byte is launched with a one-cycle tx_start once the
// UART is idle, then the UART busy period (rise then fall) is tracked before byte_done.
//   clock, reset : system clock, synchronous active-high reset
//   tx_byte      : byte to send, sampled when request is high
//   request      : one-cycle pulse, only issued while the handshake is idle
//   tx_busy      : UART transmitter busy
//   tx_data      : byte presented to the UART, stable until the byte completes
//   tx_start     : one-cycle transmit request
//   byte_done    : one-cycle pulse once the UART has finished the byte
module uart_byte_handshake
   import acsp_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic [UART_BYTE_W-1:0] tx_byte,
   input  logic                   request,
   input  logic                   tx_busy,
   output logic [UART_BYTE_W-1:0] tx_data,
   output logic                   tx_start,
   output logic                   byte_done
);

   readout_state_t state_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         byte_done <= 1'b0;
      end else begin
         tx_start  <= 1'b0;
         byte_done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (request) begin
                  tx_data <= tx_byte;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  state_q  <= WAIT_ACK;
               end
            end
            // tx_busy was low when tx_start went out, so its rise is the acknowledge.
            WAIT_ACK: begin
               if (tx_busy) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  byte_done <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sample_readout.sv
// Drains captured samples from sample_fifo and streams them to the UART, LSB byte first.
// Optional feature macro: SAMPLE_READOUT_CHECKSUM_EN appends an XOR checksum byte.
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-cycle start pulse, ignored unless idle
//   read_count   : samples to send, sampled on an accepted start
//   fifo_rd_en   : one-cycle FIFO read request
//   fifo_data    : FIFO read data, qualified by fifo_valid
//   fifo_valid   : fifo_data valid
//   fifo_empty   : FIFO has no data
//   tx_data      : byte to the UART
//   tx_start     : one-cycle UART transmit request
//   tx_busy      : UART busy
//   busy         : high from an accepted start until done
//   done         : one-cycle pulse at the end of readout
//   underrun     : sticky, FIFO ran dry before read_count samples were sent
module sample_readout
   import acsp_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 8,
   parameter int unsigned COUNT_WIDTH  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [COUNT_WIDTH-1:0]  read_count,
   output logic                    fifo_rd_en,
   input  logic [SAMPLE_WIDTH-1:0] fifo_data,
   input  logic                    fifo_valid,
   input  logic                    fifo_empty,
   output logic [UART_BYTE_W-1:0]  tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    busy,
   output logic                    done,
   output logic                    underrun
);

   localparam int unsigned BPS     = bytes_per_sample(SAMPLE_WIDTH);
   localparam int unsigned SHIFT_W = BPS * UART_BYTE_W;
   localparam logic [1:0]  LAST_IDX = 2'(BPS - 1);
   localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

   // Where the FSM goes when the sample stream ends; the checksum build sends one more byte.
`ifdef SAMPLE_READOUT_CHECKSUM_EN
   localparam readout_state_t EXIT_STATE = CHECKSUM;
   localparam logic           EXIT_REQ   = 1'b1;
`else
   localparam readout_state_t EXIT_STATE = FINISH;
   localparam logic           EXIT_REQ   = 1'b0;
`endif

   readout_state_t         state_q;
   logic [COUNT_WIDTH-1:0] cnt_q;
   logic [COUNT_WIDTH-1:0] sent_q;
   logic [SHIFT_W-1:0]     shift_q;
   logic [1:0]             idx_q;
   logic                   hs_req;
   logic [UART_BYTE_W-1:0] hs_byte;
   logic                   byte_done;

`ifdef SAMPLE_READOUT_CHECKSUM_EN
   logic [UART_BYTE_W-1:0] csum_q;
   assign hs_byte = (state_q == CHECKSUM) ? csum_q : shift_q[UART_BYTE_W-1:0];
`else
   assign hs_byte = shift_q[UART_BYTE_W-1:0];
`endif

   uart_byte_handshake u_handshake (
      .clock     (clock),
      .reset     (reset),
      .tx_byte   (hs_byte),
      .request   (hs_req),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .byte_done (byte_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sent_q     <= '0;
         shift_q    <= '0;
         idx_q      <= '0;
         hs_req     <= 1'b0;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         underrun   <= 1'b0;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         fifo_rd_en <= 1'b0;
         done       <= 1'b0;
         hs_req     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  cnt_q    <= read_count;
                  sent_q   <= '0;
                  underrun <= 1'b0;
                  busy     <= 1'b1;
`ifdef SAMPLE_READOUT_CHECKSUM_EN
                  csum_q   <= '0;
`endif
                  if (read_count == '0) begin
                     state_q <= EXIT_STATE;
                     hs_req  <= EXIT_REQ;
                  end else begin
                     state_q <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (fifo_empty) begin
                  underrun <= 1'b1;
                  state_q  <= EXIT_STATE;
                  hs_req   <= EXIT_REQ;
               end else begin
                  fifo_rd_en <= 1'b1;
                  state_q    <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (fifo_valid) begin
                  shift_q <= SHIFT_W'(fifo_data);
                  idx_q   <= '0;
                  hs_req  <= 1'b1;
                  state_q <= SEND;
               end
            end
            // The handshake runs SEND/WAIT_ACK/WAIT_DONE; here we only step bytes on byte_done.
            SEND: begin
               if (byte_done) begin
`ifdef SAMPLE_READOUT_CHECKSUM_EN
                  csum_q <= csum_q ^ shift_q[UART_BYTE_W-1:0];
`endif
                  if (idx_q != LAST_IDX) begin
                     idx_q   <= idx_q + 2'd1;
                     shift_q <= shift_q >> UART_BYTE_W;
                     hs_req  <= 1'b1;
                  end else begin
                     sent_q <= sent_q + ONE;
                     if ((sent_q + ONE) == cnt_q) begin
                        state_q <= EXIT_STATE;
                        hs_req  <= EXIT_REQ;
                     end else begin
                        state_q <= FETCH;
                     end
                  end
               end
            end
`ifdef SAMPLE_READOUT_CHECKSUM_EN
            CHECKSUM: begin
               if (byte_done) begin
                  state_q <= FINISH;
               end
            end
`endif
            FINISH: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sample_readout.md
Name: sample_readout

Overview:
- Drains captured samples from sample_fifo and streams them to the UART transmitter as bytes.
- Reader-side counterpart of the sampler→FIFO write path.
- Sits between sample_fifo and UART_com. The controller starts it after capture completes and selects its byte stream onto the transmit mux.
- Splits each SAMPLE_WIDTH-bit sample into ceil(SAMPLE_WIDTH/8) bytes and paces transfers on tx_busy.

Parameters:
- SAMPLE_WIDTH, 8: bits per captured sample. Legal range 1..32.
- COUNT_WIDTH, 16: width of the sample-count field and internal counter.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse to begin readout. Ignored unless idle.
- read_count  input  COUNT_WIDTH  number of samples to send. Sampled only on an accepted start.
- fifo_rd_en  output  1  one-cycle read request to the FIFO.
- fifo_data  input  SAMPLE_WIDTH  FIFO read data, qualified by fifo_valid.
- fifo_valid  input  1  fifo_data is valid. Arrives ≥1 cycle after fifo_rd_en.
- fifo_empty  input  1  FIFO has no data.
- tx_data  output  8  byte presented to UART. Held stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle transmit request to UART.
- tx_busy  input  1  UART transmitter busy.
- busy  output  1  high from an accepted start until done.
- done  output  1  one-cycle pulse when readout ends.
- underrun  output  1  sticky: FIFO emptied before read_count samples were sent. Cleared on the next accepted start.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-transfer aborts immediately; the partial byte is abandoned.
- BPS = ceil(SAMPLE_WIDTH/8). Bytes go out least-significant byte first; unused upper bits of the last byte are 0.
- IDLE: on start, latch read_count, clear sent-count and underrun, set busy next cycle.
  - If read_count==0, go to FINISH (done one cycle later, no FIFO read, no bytes sent).
  - Otherwise go to FETCH.
- FETCH:
  - If fifo_empty: set underrun, go to FINISH.
  - Else: pulse fifo_rd_en for exactly 1 cycle, go to WAIT_DATA.
- WAIT_DATA: on fifo_valid, latch fifo_data into the shift register, byte index = 0, go to SEND. Waits indefinitely.
- SEND: when tx_busy==0, drive tx_data = current byte, pulse tx_start 1 cycle, go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy==1, then go to WAIT_DONE. A tx_start is never reissued while here.
- WAIT_DONE: wait for tx_busy==0.
  - If byte index < BPS-1: increment index, shift register right by 8, go to SEND.
  - Else: increment sent-count.
    - If sent-count == latched count, go to FINISH.
    - Otherwise go to FETCH.
- FINISH: pulse done 1 cycle, busy falls on the same cycle, return to IDLE.
- start asserted while busy: ignored, no effect on count.
- Counter arithmetic: unsigned COUNT_WIDTH. Maximum count 2^COUNT_WIDTH-1; no wrap inside a transfer.
- Back-to-back bytes: minimum 3 cycles between tx_start pulses, plus UART busy time.

Optional Feature:
- Macro: SAMPLE_READOUT_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator covers every transmitted data byte.
  - It is cleared on an accepted start.
  - After the last sample, or on an underrun exit, a CHECKSUM state sends the accumulator as one extra byte using the same SEND/WAIT_ACK/WAIT_DONE handshake, then goes to FINISH.
  - read_count==0 sends a single checksum byte 0x00.
- Undefined: no accumulator, no CHECKSUM state; byte stream is samples only.

Decomposition:
- Shared package acsp_pkg contains:
  - readout_state_t enum (IDLE, FETCH, WAIT_DATA, SEND, WAIT_ACK, WAIT_DONE, CHECKSUM, FINISH).
  - bytes_per_sample(width) function.
  - UART_BYTE_W = 8.
- Sub-module uart_byte_handshake: owns the SEND/WAIT_ACK/WAIT_DONE sequencing.
  - Inputs: byte, request.
  - Outputs: tx_data, tx_start, byte_done pulse.
  - The parent FSM issues requests and steps bytes.

Test Plan:
- SAMPLE_WIDTH=8, read_count=3, FIFO holds 0x11,0x22,0x33, UART busy 10 cycles per byte:
  - Expect tx bytes 0x11,0x22,0x33.
  - Expect 3 fifo_rd_en pulses, done once, underrun=0.
  - With checksum enabled, expect a fourth byte 0x00.
- SAMPLE_WIDTH=16, read_count=2, FIFO 0xBEEF,0x1234:
  - Expect bytes 0xEF,0xBE,0x34,0x12.
  - Expect exactly 2 reads.
- read_count=0:
  - Expect done 2 cycles after start.
  - Expect no fifo_rd_en, no tx_start (checksum build: a single 0x00).
- read_count=5, FIFO holds 2 samples:
  - Expect 2 samples sent, underrun=1, done.
  - Expect underrun cleared on the next start.
- UART asserts tx_busy 3 cycles late; start pulsed mid-transfer:
  - Expect no duplicate tx_start and the start ignored.
- Reset asserted during WAIT_DONE:
  - Expect all outputs 0 next cycle, then a clean readout after a new start.
